hazard_unit: RTL and testbench

// - Produces the stall/flush controls consumed by the pipeline registers (FETCH, DEC->EXE, EXE->MEM) and the EXE operand forwarding selects.
// - Covers load-use interlock, taken-branch/jump redirect flush, and a multi-cycle data-memory wait interlock with timeout watchdog.
// - Keeps saturating stall/flush performance counters. Sits beside the 5-stage datapath.

---
 rtl/hazard_unit.sv | 167 ++++++++++++++++
 tb/tb_hazard_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit
// Generates the stall and flush controls for the FETCH, DEC->EXE and EXE->MEM
// pipeline registers, and the EXE operand forwarding selects.
// Handles the following hazards and events:
//   - load-use interlock
//   - taken-branch/jump redirect flush
//   - data-memory wait interlock, guarded by a timeout watchdog
// Also keeps saturating performance counters for stall and flush cycles.
module hazard_unit #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_Rs1D,
    input  logic [4:0]       i_Rs2D,
    input  logic [4:0]       i_Rs1E,
    input  logic [4:0]       i_Rs2E,
    input  logic [4:0]       i_RdE,
    input  logic             i_ResultSrcE,
    input  logic             i_PCSrcE,
    input  logic [4:0]       i_RdM,
    input  logic [4:0]       i_RdW,
    input  logic             i_RegWriteM,
    input  logic             i_RegWriteW,
    input  logic             i_MemReqM,
    input  logic             i_MemReadyM,
    output logic             o_StallF,
    output logic             o_StallD,
    output logic             o_StallE,
    output logic             o_StallM,
    output logic             o_FlushD,
    output logic             o_FlushE,
    output logic [1:0]       o_ForwardAE,
    output logic [1:0]       o_ForwardBE,
    output logic             o_MemTimeout,
    output logic [CNT_W-1:0] o_StallCycles,
    output logic [CNT_W-1:0] o_FlushCount
);

    // The wait counter only has to reach MEM_TIMEOUT-1. On the cycle after
    // that value, a still-pending access trips the watchdog.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_memTimeout;
    logic [CNT_W-1:0]  r_stallCycles;
    logic [CNT_W-1:0]  r_flushCount;

    logic w_lwStall;
    logic w_memBusy;

    assign w_lwStall = i_ResultSrcE && (i_RdE != 5'd0) &&
                       ((i_RdE == i_Rs1D) || (i_RdE == i_Rs2D));
    assign w_memBusy = i_MemReqM && !i_MemReadyM;

    // Select the forwarding source for each EXE operand.
    // The MEM stage holds the younger result, so it takes priority over WB.
    // x0 is never forwarded, because bubbles carry Rd=0.
    always_comb begin
        o_ForwardAE = 2'b00;
        o_ForwardBE = 2'b00;
        if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == i_Rs1E)) begin
            o_ForwardAE = 2'b10;
        end else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == i_Rs1E)) begin
            o_ForwardAE = 2'b01;
        end
        if (i_RegWriteM && (i_RdM != 5'd0) && (i_RdM == i_Rs2E)) begin
            o_ForwardBE = 2'b10;
        end else if (i_RegWriteW && (i_RdW != 5'd0) && (i_RdW == i_Rs2E)) begin
            o_ForwardBE = 2'b01;
        end
    end

    // Decode the stage controls from the current state and this cycle's inputs.
    // Priority, highest first:
    //   1. memory wait: freezes everything (the stage registers prefer stall over flush)
    //   2. redirect: discards the wrong-path DEC instruction, which cancels any load-use
    //   3. load-use: inserts a single bubble into EXE
    always_comb begin
        o_StallF = 1'b0;
        o_StallD = 1'b0;
        o_StallE = 1'b0;
        o_StallM = 1'b0;
        o_FlushD = 1'b0;
        o_FlushE = 1'b0;
        if (!i_rst) begin
            if (r_state == ST_TIMEOUT || w_memBusy) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_StallE = 1'b1;
                o_StallM = 1'b1;
            end else if (i_PCSrcE) begin
                o_FlushD = 1'b1;
                o_FlushE = 1'b1;
            end else if (w_lwStall) begin
                o_StallF = 1'b1;
                o_StallD = 1'b1;
                o_FlushE = 1'b1;
            end
        end
    end

    // Track the memory wait, count waiting cycles and latch a sticky watchdog
    // error. Once in TIMEOUT, only reset leaves it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_RUN;
            r_waitCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_memBusy) begin
                        r_state   <= ST_MEMWAIT;
                        r_waitCnt <= '0;
                    end
                end
                ST_MEMWAIT: begin
                    if (i_MemReadyM) begin
                        r_state <= ST_RUN;
                    end else if (r_waitCnt == WAIT_LAST) begin
                        r_state      <= ST_TIMEOUT;
                        r_memTimeout <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                ST_TIMEOUT: begin
                    r_state <= ST_TIMEOUT;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Count stall and flush cycles. Both counters hold at all-ones instead of
    // wrapping, so long runs are never misreported as short ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (o_StallF && (r_stallCycles != {CNT_W{1'b1}})) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (o_FlushE && (r_flushCount != {CNT_W{1'b1}})) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
        end
    end

    assign o_MemTimeout  = r_memTimeout;
    assign o_StallCycles = r_stallCycles;
    assign o_FlushCount  = r_flushCount;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Directed bench for hazard_unit, with narrow counters and a short watchdog.
// Each step pushes its expected controls and counters onto a scoreboard.
// The scoreboard entry is popped and compared mid-cycle, away from the clock edge.
module tb_hazard_unit;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 4;

    localparam logic [5:0] C_NONE  = 6'b000000;
    localparam logic [5:0] C_MEM   = 6'b111100;
    localparam logic [5:0] C_FLUSH = 6'b000011;
    localparam logic [5:0] C_LW    = 6'b110001;

    typedef struct packed {
        logic [5:0]       ctrl;
        logic [1:0]       fwdA;
        logic [1:0]       fwdB;
        logic             memTimeout;
        logic [CNT_W-1:0] stallCycles;
        logic [CNT_W-1:0] flushCount;
    } expect_t;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic resultSrcE, pcSrcE, regWriteM, regWriteW, memReqM, memReadyM;
    logic stallF, stallD, stallE, stallM, flushD, flushE, memTimeout;
    logic [1:0] forwardAE, forwardBE;
    logic [CNT_W-1:0] stallCycles, flushCount;

    expect_t scoreboard[$];
    string curTag;
    logic [CNT_W-1:0] modelStall;
    logic [CNT_W-1:0] modelFlush;
    int checks = 0;
    int failures = 0;

    hazard_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_Rs1D(rs1D), .i_Rs2D(rs2D), .i_Rs1E(rs1E), .i_Rs2E(rs2E),
        .i_RdE(rdE), .i_ResultSrcE(resultSrcE), .i_PCSrcE(pcSrcE),
        .i_RdM(rdM), .i_RdW(rdW), .i_RegWriteM(regWriteM), .i_RegWriteW(regWriteW),
        .i_MemReqM(memReqM), .i_MemReadyM(memReadyM),
        .o_StallF(stallF), .o_StallD(stallD), .o_StallE(stallE), .o_StallM(stallM),
        .o_FlushD(flushD), .o_FlushE(flushE),
        .o_ForwardAE(forwardAE), .o_ForwardBE(forwardBE),
        .o_MemTimeout(memTimeout), .o_StallCycles(stallCycles), .o_FlushCount(flushCount)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Return every input except reset to its idle value.
    task automatic clearInputs();
        rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0;
        rdE = 5'd0; rdM = 5'd0; rdW = 5'd0;
        resultSrcE = 1'b0; pcSrcE = 1'b0; regWriteM = 1'b0; regWriteW = 1'b0;
        memReqM = 1'b0; memReadyM = 1'b0;
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic checkOutput();
        expect_t e;
        checks++;
        assert (scoreboard.size() > 0) else begin
            failures++;
            $error("[TB] FAIL %s scoreboard observed=empty expected=entry", curTag);
        end
        if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checks++;
            assert ({stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE}
                    === {e.ctrl, e.fwdA, e.fwdB}) else begin
                failures++;
                $error("[TB] FAIL %s ctrl_fwd observed=%b expected=%b", curTag,
                       {stallF, stallD, stallE, stallM, flushD, flushE, forwardAE, forwardBE},
                       {e.ctrl, e.fwdA, e.fwdB});
            end
            checks++;
            assert ({memTimeout, stallCycles, flushCount}
                    === {e.memTimeout, e.stallCycles, e.flushCount}) else begin
                failures++;
                $error("[TB] FAIL %s tmo_stall_flush observed=%b/%0d/%0d expected=%b/%0d/%0d",
                       curTag, memTimeout, stallCycles, flushCount,
                       e.memTimeout, e.stallCycles, e.flushCount);
            end
        end
    endtask

    // Record the expectation for the inputs already driven and check it mid-cycle.
    // Then cross one clock edge and advance the saturating counter model.
    task automatic applyStimulus(input string tag, input logic [5:0] ctrl,
                                 input logic [1:0] fwdA, input logic [1:0] fwdB,
                                 input logic tmo);
        expect_t e;
        e.ctrl        = ctrl;
        e.fwdA        = fwdA;
        e.fwdB        = fwdB;
        e.memTimeout  = tmo;
        e.stallCycles = modelStall;
        e.flushCount  = modelFlush;
        scoreboard.push_back(e);
        curTag = tag;
        #3;
        checkOutput();
        @(posedge clk);
        #1;
        if (rst) begin
            modelStall = '0;
            modelFlush = '0;
        end else begin
            if (ctrl[5] && modelStall != {CNT_W{1'b1}}) modelStall = modelStall + 1'b1;
            if (ctrl[0] && modelFlush != {CNT_W{1'b1}}) modelFlush = modelFlush + 1'b1;
        end
    endtask

    // Directed sequence of steps.
    initial begin
        rst = 1'b1;
        clearInputs();
        modelStall = '0;
        modelFlush = '0;
        repeat (2) @(posedge clk);
        #1;

        memReqM = 1'b1;
        applyStimulus("reset_quiet", C_NONE, 2'b00, 2'b00, 1'b0);

        rst = 1'b0;
        clearInputs();
        rs1E = 5'd5; rdM = 5'd5; regWriteM = 1'b1; rdW = 5'd5; regWriteW = 1'b1;
        applyStimulus("fwd_mem_beats_wb", C_NONE, 2'b10, 2'b00, 1'b0);
        rdM = 5'd0;
        applyStimulus("fwd_wb_when_rdm0", C_NONE, 2'b01, 2'b00, 1'b0);
        rdW = 5'd0;
        applyStimulus("fwd_none_x0", C_NONE, 2'b00, 2'b00, 1'b0);
        rs2E = 5'd9; rdM = 5'd9; regWriteM = 1'b0; rdW = 5'd9; regWriteW = 1'b1;
        applyStimulus("fwdB_wb_regwritem0", C_NONE, 2'b00, 2'b01, 1'b0);

        clearInputs();
        resultSrcE = 1'b1; rdE = 5'd7; rs2D = 5'd7;
        applyStimulus("load_use", C_LW, 2'b00, 2'b00, 1'b0);
        clearInputs();
        applyStimulus("after_load_use", C_NONE, 2'b00, 2'b00, 1'b0);
        resultSrcE = 1'b1; rdE = 5'd7; rs2D = 5'd7; pcSrcE = 1'b1;
        applyStimulus("redirect_over_lw", C_FLUSH, 2'b00, 2'b00, 1'b0);
        clearInputs();
        applyStimulus("idle_after_flush", C_NONE, 2'b00, 2'b00, 1'b0);
        resultSrcE = 1'b1; rdE = 5'd0;
        applyStimulus("load_x0_no_stall", C_NONE, 2'b00, 2'b00, 1'b0);

        clearInputs();
        memReqM = 1'b1;
        applyStimulus("memwait_1", C_MEM, 2'b00, 2'b00, 1'b0);
        pcSrcE = 1'b1;
        applyStimulus("memwait_2_pcsrc", C_MEM, 2'b00, 2'b00, 1'b0);
        pcSrcE = 1'b0; resultSrcE = 1'b1; rdE = 5'd3; rs1D = 5'd3;
        applyStimulus("memwait_3_lw", C_MEM, 2'b00, 2'b00, 1'b0);
        clearInputs();
        memReqM = 1'b1; memReadyM = 1'b1; pcSrcE = 1'b1;
        applyStimulus("ready_with_redirect", C_FLUSH, 2'b00, 2'b00, 1'b0);
        clearInputs();
        applyStimulus("back_in_run", C_NONE, 2'b00, 2'b00, 1'b0);

        memReqM = 1'b1;
        applyStimulus("busy_from_run", C_MEM, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            applyStimulus($sformatf("memwait_cycle_%0d", i + 1), C_MEM, 2'b00, 2'b00, 1'b0);
        end
        clearInputs();
        applyStimulus("timeout_entered", C_MEM, 2'b00, 2'b00, 1'b1);
        pcSrcE = 1'b1; memReqM = 1'b1; memReadyM = 1'b1;
        applyStimulus("timeout_ignores_inputs", C_MEM, 2'b00, 2'b00, 1'b1);
        clearInputs();
        for (int i = 0; i < 6; i++) begin
            applyStimulus($sformatf("timeout_hold_%0d", i), C_MEM, 2'b00, 2'b00, 1'b1);
        end
        applyStimulus("stall_counter_saturated", C_MEM, 2'b00, 2'b00, 1'b1);

        rst = 1'b1;
        memReqM = 1'b1;
        applyStimulus("reset_in_timeout", C_NONE, 2'b00, 2'b00, 1'b1);
        rst = 1'b0;
        clearInputs();
        applyStimulus("after_reset_run", C_NONE, 2'b00, 2'b00, 1'b0);
        resultSrcE = 1'b1; rdE = 5'd12; rs1D = 5'd12;
        applyStimulus("load_use_after_reset", C_LW, 2'b00, 2'b00, 1'b0);
        clearInputs();
        applyStimulus("final_idle", C_NONE, 2'b00, 2'b00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
